// File: rtl/mem_loader_pkg.sv
// Boot loader shared definitions: stream header field layout,
// target encodings and a header decode helper.
package mem_loader_pkg;

  localparam int LDR_TGT_BIT  = 31;
  localparam int LDR_LAST_BIT = 30;
  localparam int LDR_CNT_MSB  = 24;
  localparam int LDR_CNT_LSB  = 16;
  localparam int LDR_ADDR_MSB = 9;
  localparam int LDR_ADDR_LSB = 0;

  localparam int LDR_CNT_W =
    LDR_CNT_MSB - LDR_CNT_LSB + 1;

  localparam logic LDR_TGT_IMEM = 1'b0;
  localparam logic LDR_TGT_DMEM = 1'b1;

  typedef struct packed {
    logic                 tgt;
    logic                 last;
    logic [LDR_CNT_W-1:0] cnt;
  } ldr_hdr_t;

  function automatic ldr_hdr_t ldr_decode(
    input logic [31:0] w
  );
    ldr_hdr_t h;
    h.tgt  = w[LDR_TGT_BIT];
    h.last = w[LDR_LAST_BIT];
    h.cnt  = w[LDR_CNT_MSB:LDR_CNT_LSB];
    return h;
  endfunction

endpackage

// File: rtl/mem_loader.sv
// Streams header + payload words into the instruction and data BRAMs,
// then releases the core by raising load_done / dropping pc_stall.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  load_done,
  output logic                  pc_stall,
  output logic                  rd_enb,
  output logic                  load_err
);

  typedef enum logic [1:0] {
    S_HDR,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [LDR_CNT_W-1:0] MAX_CNT =
    LDR_CNT_W'(MAX_WORDS);

  state_t                state_q, state_d;
  logic                  tgt_q, tgt_d;
  logic                  last_q, last_d;
  logic [LDR_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                  s_ready_q, s_ready_d;
  logic [ADDR_WIDTH-1:0] i_w_addr_q, i_w_addr_d;
  logic [DATA_WIDTH-1:0] i_w_dat_q, i_w_dat_d;
  logic                  i_w_enb_q, i_w_enb_d;
  logic [ADDR_WIDTH-1:0] d_w_addr_q, d_w_addr_d;
  logic [DATA_WIDTH-1:0] d_w_dat_q, d_w_dat_d;
  logic                  d_w_enb_q, d_w_enb_d;
  logic                  load_done_q, load_done_d;
  logic                  pc_stall_q, pc_stall_d;
  logic                  rd_enb_q, rd_enb_d;
  logic                  load_err_q, load_err_d;

  ldr_hdr_t hdr;
  logic     accept;
  logic     hdr_zero;
  logic     hdr_big;
  logic     done_d;

  always_comb begin
    hdr      = ldr_decode(s_data[31:0]);
    accept   = s_valid && s_ready_q;
    hdr_zero = (hdr.cnt == '0);
    hdr_big  = (hdr.cnt > MAX_CNT);

    state_d    = state_q;
    tgt_d      = tgt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    i_w_addr_d = i_w_addr_q;
    i_w_dat_d  = i_w_dat_q;
    i_w_enb_d  = 1'b0;
    d_w_addr_d = d_w_addr_q;
    d_w_dat_d  = d_w_dat_q;
    d_w_enb_d  = 1'b0;

    unique case (state_q)
      S_HDR: begin
        if (accept) begin
          unique case (1'b1)
            hdr_zero && hdr.last:
              state_d = S_DONE;
            hdr_zero && !hdr.last:
              state_d = S_HDR;
            hdr_big:
              state_d = S_ERR;
            default: begin
              tgt_d   = hdr.tgt;
              last_d  = hdr.last;
              cnt_d   = hdr.cnt;
              addr_d  = {s_data[ADDR_WIDTH-1:2], 2'b00};
              state_d = S_DATA;
            end
          endcase
        end
      end
      S_DATA: begin
        if (accept) begin
          if (tgt_q == LDR_TGT_DMEM) begin
            d_w_enb_d  = 1'b1;
            d_w_addr_d = addr_q;
            d_w_dat_d  = s_data;
          end else begin
            i_w_enb_d  = 1'b1;
            i_w_addr_d = addr_q;
            i_w_dat_d  = s_data;
          end
          // address wraps naturally at the BRAM size
          addr_d = addr_q + ADDR_WIDTH'(4);
          cnt_d  = cnt_q - LDR_CNT_W'(1);
          if (cnt_q == LDR_CNT_W'(1))
            state_d = last_q ? S_DONE : S_HDR;
        end
      end
      S_DONE: ;
      S_ERR:  ;
    endcase

    // hold done back one cycle behind the final write strobe
    done_d      = (state_d == S_DONE) &&
                  !(i_w_enb_d || d_w_enb_d);
    load_done_d = done_d;
    rd_enb_d    = done_d;
    pc_stall_d  = !done_d;
    load_err_d  = (state_d == S_ERR);
    s_ready_d   = (state_d == S_HDR) ||
                  (state_d == S_DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HDR;
      tgt_q       <= LDR_TGT_IMEM;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      s_ready_q   <= 1'b0;
      i_w_addr_q  <= '0;
      i_w_dat_q   <= '0;
      i_w_enb_q   <= 1'b0;
      d_w_addr_q  <= '0;
      d_w_dat_q   <= '0;
      d_w_enb_q   <= 1'b0;
      load_done_q <= 1'b0;
      pc_stall_q  <= 1'b1;
      rd_enb_q    <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      s_ready_q   <= s_ready_d;
      i_w_addr_q  <= i_w_addr_d;
      i_w_dat_q   <= i_w_dat_d;
      i_w_enb_q   <= i_w_enb_d;
      d_w_addr_q  <= d_w_addr_d;
      d_w_dat_q   <= d_w_dat_d;
      d_w_enb_q   <= d_w_enb_d;
      load_done_q <= load_done_d;
      pc_stall_q  <= pc_stall_d;
      rd_enb_q    <= rd_enb_d;
      load_err_q  <= load_err_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign i_w_addr  = i_w_addr_q;
  assign i_w_dat   = i_w_dat_q;
  assign i_w_enb   = i_w_enb_q;
  assign d_w_addr  = d_w_addr_q;
  assign d_w_dat   = d_w_dat_q;
  assign d_w_enb   = d_w_enb_q;
  assign load_done = load_done_q;
  assign pc_stall  = pc_stall_q;
  assign rd_enb    = rd_enb_q;
  assign load_err  = load_err_q;

endmodule
